// File: rtl/uart_echo_buffer.sv
`default_nettype none
// ============================================================================
// Module   : uart_echo_buffer
// Brief    : FIFO-buffered UART echo path; replays received characters to the
//            transmitter as one-cycle enable pulses with an optional idle gap.
//            Define UART_ECHO_ERR_FILTER_EN to drop characters flagged with
//            parity or framing errors.
// Revision : 1.0 - initial release
// ============================================================================
module uart_echo_buffer #(
    parameter int p_data_width    = 7,
    parameter int p_depth_log2    = 4,
    parameter int p_tx_gap_cycles = 0
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    rx_data_ready_i,
    input  logic [p_data_width-1:0] rx_data_i,
    input  logic                    parity_err_i,
    input  logic                    framing_err_i,
    input  logic                    tx_data_sent_i,
    input  logic                    tx_busy_i,
    output logic                    tx_enable_o,
    output logic [p_data_width-1:0] tx_data_o,
    output logic [p_depth_log2:0]   fifo_level_o,
    output logic                    fifo_empty_o,
    output logic                    fifo_full_o,
    output logic [7:0]              overflow_cnt_o,
    output logic [7:0]              err_drop_cnt_o
);

    localparam int c_depth = 1 << p_depth_log2;
    localparam int c_gap_w = (p_tx_gap_cycles > 1) ? $clog2(p_tx_gap_cycles) : 1;
    localparam logic [c_gap_w-1:0] c_gap_load =
        (p_tx_gap_cycles > 0) ? c_gap_w'(p_tx_gap_cycles - 1) : '0;
    localparam logic [p_depth_log2:0] c_full_level = {1'b1, {p_depth_log2{1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_WAIT_DONE = 2'd1,
        S_GAP       = 2'd2
    } state_t;

    logic [p_data_width-1:0] r_mem [c_depth];
    logic [p_depth_log2-1:0] r_wr_ptr;
    logic [p_depth_log2-1:0] r_rd_ptr;
    logic [p_depth_log2:0]   r_level;
    logic                    r_rx_ready_q;
    logic                    r_tx_sent_q;
    logic [7:0]              r_overflow_cnt;
    logic [7:0]              r_err_drop_cnt;
    state_t                  r_state;
    logic [c_gap_w-1:0]      r_gap_cnt;
    logic                    r_tx_enable;
    logic [p_data_width-1:0] r_tx_data;

    logic w_push_req;
    logic w_sent_rise;
    logic w_rx_err;
    logic w_store_req;
    logic w_empty;
    logic w_full;
    logic w_pop;
    logic w_push;
    logic w_overflow;
    logic w_drop;

    assign w_push_req  = rx_data_ready_i & ~r_rx_ready_q;
    assign w_sent_rise = tx_data_sent_i & ~r_tx_sent_q;

`ifdef UART_ECHO_ERR_FILTER_EN
    assign w_rx_err = parity_err_i | framing_err_i;
`else
    // Error flags are read but masked so every request is stored.
    assign w_rx_err = 1'b0 & (parity_err_i | framing_err_i);
`endif

    assign w_empty     = (r_level == '0);
    assign w_full      = (r_level == c_full_level);
    assign w_pop       = (r_state == S_IDLE) & ~w_empty & ~tx_busy_i;
    assign w_store_req = w_push_req & ~w_rx_err;
    // A pop on the same edge frees the slot, so a full FIFO still accepts.
    assign w_push      = w_store_req & (~w_full | w_pop);
    assign w_overflow  = w_store_req & w_full & ~w_pop;
    assign w_drop      = w_push_req & w_rx_err;

    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= rx_data_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_wr_ptr       <= '0;
            r_rd_ptr       <= '0;
            r_level        <= '0;
            r_rx_ready_q   <= 1'b0;
            r_tx_sent_q    <= 1'b0;
            r_overflow_cnt <= '0;
            r_err_drop_cnt <= '0;
            r_state        <= S_IDLE;
            r_gap_cnt      <= '0;
            r_tx_enable    <= 1'b0;
            r_tx_data      <= '0;
        end else begin
            r_rx_ready_q <= rx_data_ready_i;
            r_tx_sent_q  <= tx_data_sent_i;

            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_push && !w_pop) begin
                r_level <= r_level + 1'b1;
            end else if (w_pop && !w_push) begin
                r_level <= r_level - 1'b1;
            end

            if (w_overflow && (r_overflow_cnt != 8'hFF)) begin
                r_overflow_cnt <= r_overflow_cnt + 8'd1;
            end
            if (w_drop && (r_err_drop_cnt != 8'hFF)) begin
                r_err_drop_cnt <= r_err_drop_cnt + 8'd1;
            end

            r_tx_enable <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_pop) begin
                        r_tx_data   <= r_mem[r_rd_ptr];
                        r_tx_enable <= 1'b1;
                        r_state     <= S_WAIT_DONE;
                    end
                end
                S_WAIT_DONE: begin
                    if (w_sent_rise) begin
                        if (p_tx_gap_cycles > 0) begin
                            r_gap_cnt <= c_gap_load;
                            r_state   <= S_GAP;
                        end else begin
                            r_state <= S_IDLE;
                        end
                    end
                end
                S_GAP: begin
                    if (r_gap_cnt == '0) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_gap_cnt <= r_gap_cnt - 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign tx_enable_o    = r_tx_enable;
    assign tx_data_o      = r_tx_data;
    assign fifo_level_o   = r_level;
    assign fifo_empty_o   = w_empty;
    assign fifo_full_o    = w_full;
    assign overflow_cnt_o = r_overflow_cnt;
    assign err_drop_cnt_o = r_err_drop_cnt;

endmodule
`default_nettype wire

// File: tb/tb_uart_echo_buffer.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_echo_buffer
// Brief    : Self-checking bench; two echo buffers (depth 16/no gap and
//            depth 4/gap 5) checked every cycle against a queue-based model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_echo_buffer;

    localparam int c_w      = 7;
    localparam int c_frame  = 20;
    localparam int c_depth0 = 16;
    localparam int c_depth1 = 4;
    localparam int c_gap0   = 0;
    localparam int c_gap1   = 5;
`ifdef UART_ECHO_ERR_FILTER_EN
    localparam bit c_filt = 1'b1;
`else
    localparam bit c_filt = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           rst   = 1'b1;
    logic           rdy   = 1'b0;
    logic [c_w-1:0] rdata = '0;
    logic           perr  = 1'b0;
    logic           ferr  = 1'b0;
    logic           busy  = 1'b0;
    logic           inj   = 1'b0;
    logic [1:0]     sent_lvl = 2'b00;
    logic [1:0]     sent_in;
    assign sent_in = sent_lvl | {inj, inj};

    logic           en0, en1, emp0, emp1, ful0, ful1;
    logic [c_w-1:0] txd0, txd1;
    logic [4:0]     lvl0;
    logic [2:0]     lvl1;
    logic [7:0]     ovf0, ovf1, err0, err1;

    uart_echo_buffer #(.p_data_width(c_w), .p_depth_log2(4), .p_tx_gap_cycles(c_gap0)) u_dut0 (
        .clk_i(clk), .rst_i(rst), .rx_data_ready_i(rdy), .rx_data_i(rdata),
        .parity_err_i(perr), .framing_err_i(ferr), .tx_data_sent_i(sent_in[0]),
        .tx_busy_i(busy), .tx_enable_o(en0), .tx_data_o(txd0), .fifo_level_o(lvl0),
        .fifo_empty_o(emp0), .fifo_full_o(ful0), .overflow_cnt_o(ovf0), .err_drop_cnt_o(err0)
    );

    uart_echo_buffer #(.p_data_width(c_w), .p_depth_log2(2), .p_tx_gap_cycles(c_gap1)) u_dut1 (
        .clk_i(clk), .rst_i(rst), .rx_data_ready_i(rdy), .rx_data_i(rdata),
        .parity_err_i(perr), .framing_err_i(ferr), .tx_data_sent_i(sent_in[1]),
        .tx_busy_i(busy), .tx_enable_o(en1), .tx_data_o(txd1), .fifo_level_o(lvl1),
        .fifo_empty_o(emp1), .fifo_full_o(ful1), .overflow_cnt_o(ovf1), .err_drop_cnt_o(err1)
    );

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_on = 1'b0;

    // Model: a queue of waiting characters plus "waiting for done" / gap countdown
    logic [c_w-1:0] mq [2][$];
    logic [c_w-1:0] tx_log [2][$];
    int             m_ovf [2]   = '{0, 0};
    int             m_err [2]   = '{0, 0};
    int             m_phase [2] = '{0, 0};
    int             m_gap_left [2] = '{0, 0};
    logic           m_en [2]    = '{1'b0, 1'b0};
    logic [c_w-1:0] m_data [2]  = '{'0, '0};
    logic           m_prev_rdy [2]  = '{1'b0, 1'b0};
    logic           m_prev_sent [2] = '{1'b0, 1'b0};
    int             rcnt [2] = '{0, 0};
    int             hcnt [2] = '{0, 0};

    function automatic int depth_of(input int k);
        return (k == 0) ? c_depth0 : c_depth1;
    endfunction

    function automatic int gap_of(input int k);
        return (k == 0) ? c_gap0 : c_gap1;
    endfunction

    always @(posedge clk) begin : model
        bit req, rise, pop, bad;
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                mq[k].delete();
                m_ovf[k] = 0; m_err[k] = 0; m_phase[k] = 0; m_gap_left[k] = 0;
                m_en[k] = 1'b0; m_data[k] = '0;
                m_prev_rdy[k] = 1'b0; m_prev_sent[k] = 1'b0;
            end else begin
                req  = rdy && !m_prev_rdy[k];
                rise = sent_in[k] && !m_prev_sent[k];
                pop  = (m_phase[k] == 0) && (mq[k].size() > 0) && !busy;
                bad  = c_filt && (perr || ferr);
                m_en[k] = pop;
                if (pop) m_data[k] = mq[k].pop_front();
                if (req) begin
                    if (bad) begin
                        if (m_err[k] < 255) m_err[k]++;
                    end else if (mq[k].size() == depth_of(k)) begin
                        if (m_ovf[k] < 255) m_ovf[k]++;
                    end else begin
                        mq[k].push_back(rdata);
                    end
                end
                if (pop) begin
                    m_phase[k] = 1;
                end else if (m_phase[k] == 1 && rise) begin
                    m_gap_left[k] = gap_of(k);
                    m_phase[k]    = (gap_of(k) > 0) ? 2 : 0;
                end else if (m_phase[k] == 2) begin
                    m_gap_left[k]--;
                    if (m_gap_left[k] == 0) m_phase[k] = 0;
                end
                m_prev_rdy[k]  = rdy;
                m_prev_sent[k] = sent_in[k];
            end
        end
    end

    // Transmitter stand-in: completion level rises a frame time after each expected pulse
    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (m_en[k]) begin
                rcnt[k] = c_frame;
                sent_lvl[k] = 1'b0;
            end else if (rcnt[k] > 0) begin
                rcnt[k]--;
                if (rcnt[k] == 0) begin
                    sent_lvl[k] = 1'b1;
                    hcnt[k] = 4;
                end
            end else if (hcnt[k] > 0) begin
                hcnt[k]--;
                if (hcnt[k] == 0) sent_lvl[k] = 1'b0;
            end
        end
    end

    task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s dut%0d @%0t: got %0h expected %0h", nm, k, $time, act, exp);
        end
    endtask

    task automatic chk_inst(input int k, input logic en, input logic [c_w-1:0] d, input logic [31:0] lvl,
                            input logic emp, input logic ful, input logic [7:0] ov, input logic [7:0] er);
        int sz;
        sz = mq[k].size();
        chk("tx_enable", k, 32'(en), 32'(m_en[k]));
        chk("tx_data", k, 32'(d), 32'(m_data[k]));
        chk("fifo_level", k, lvl, 32'(sz));
        chk("fifo_empty", k, 32'(emp), 32'(sz == 0));
        chk("fifo_full", k, 32'(ful), 32'(sz == depth_of(k)));
        chk("overflow_cnt", k, 32'(ov), 32'(m_ovf[k]));
        chk("err_drop_cnt", k, 32'(er), 32'(m_err[k]));
    endtask

    always @(negedge clk) begin
        if (en0 === 1'b1) tx_log[0].push_back(txd0);
        if (en1 === 1'b1) tx_log[1].push_back(txd1);
        if (chk_on) begin
            chk_inst(0, en0, txd0, 32'(lvl0), emp0, ful0, ovf0, err0);
            chk_inst(1, en1, txd1, 32'(lvl1), emp1, ful1, ovf1, err1);
        end
    end

    // Expected characters packed one per byte, first-sent in the most significant used byte
    task automatic chk_log(input string nm, input int k, input logic [63:0] exp, input int n);
        logic [c_w-1:0] e;
        chk({nm, "_count"}, k, 32'(tx_log[k].size()), 32'(n));
        for (int i = 0; i < n && i < tx_log[k].size(); i++) begin
            e = exp[8*(n-1-i) +: c_w];
            chk({nm, "_char"}, k, 32'(tx_log[k][i]), 32'(e));
        end
        tx_log[k].delete();
    endtask

    task automatic push(input logic [c_w-1:0] c, input logic pe, input logic fe);
        rdy = 1'b1; rdata = c; perr = pe; ferr = fe;
        @(negedge clk);
        rdy = 1'b0; perr = 1'b0; ferr = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk_on = 1'b1;
        chk("reset_level", 1, 32'(lvl1), 32'd0);
        chk("reset_empty", 1, 32'(emp1), 32'd1);
        chk("reset_data", 0, 32'(txd0), 32'd0);
        rst = 1'b0;

        // single echo: enable two edges after the data-ready rise
        @(negedge clk);
        rdy = 1'b1; rdata = 7'h41;
        @(negedge clk);
        rdy = 1'b0;
        chk("echo_level", 0, 32'(lvl0), 32'd1);
        @(negedge clk);
        chk("echo_enable", 0, 32'(en0), 32'd1);
        chk("echo_data", 0, 32'(txd0), 32'h41);
        chk("echo_enable", 1, 32'(en1), 32'd1);
        repeat (40) @(negedge clk);
        chk_log("echo", 0, 64'h41, 1);
        chk_log("echo", 1, 64'h41, 1);

        // burst and overflow while the transmitter is stalled
        busy = 1'b1;
        for (int i = 0; i < 4; i++) push(7'(8'h10 + i), 1'b0, 1'b0);
        chk("burst_full", 1, 32'(ful1), 32'd1);
        chk("burst_level", 1, 32'(lvl1), 32'd4);
        push(7'h20, 1'b0, 1'b0);
        push(7'h21, 1'b0, 1'b0);
        chk("overflow", 1, 32'(ovf1), 32'd2);
        chk("overflow", 0, 32'(ovf0), 32'd0);
        chk("deep_level", 0, 32'(lvl0), 32'd6);
        busy = 1'b0;
        repeat (250) @(negedge clk);
        chk_log("burst", 1, 64'h10111213, 4);
        chk_log("burst", 0, 64'h101112132021, 6);

        // push on the pop edge while full
        busy = 1'b1;
        for (int i = 0; i < 4; i++) push(7'(8'h30 + i), 1'b0, 1'b0);
        chk("pp_full", 1, 32'(ful1), 32'd1);
        busy = 1'b0; rdy = 1'b1; rdata = 7'h34;
        @(negedge clk);
        rdy = 1'b0;
        chk("pp_level", 1, 32'(lvl1), 32'd4);
        chk("pp_enable", 1, 32'(en1), 32'd1);
        repeat (300) @(negedge clk);
        chk_log("pushpop", 1, 64'h3031323334, 5);
        chk_log("pushpop", 0, 64'h3031323334, 5);

        // receiver error flags
        push(7'h55, 1'b1, 1'b0);
        push(7'h56, 1'b0, 1'b0);
        push(7'h57, 1'b0, 1'b1);
        repeat (120) @(negedge clk);
        if (c_filt) begin
            chk("err_drop", 1, 32'(err1), 32'd2);
            chk_log("errfilt", 1, 64'h56, 1);
            chk_log("errfilt", 0, 64'h56, 1);
        end else begin
            chk("err_drop", 1, 32'(err1), 32'd0);
            chk_log("errpass", 1, 64'h555657, 3);
            chk_log("errpass", 0, 64'h555657, 3);
        end

        // completion edge while idle must not trigger anything
        inj = 1'b1;
        repeat (3) @(negedge clk);
        inj = 1'b0;
        repeat (3) @(negedge clk);
        chk("stray_sent_enable", 0, 32'(en0), 32'd0);
        chk_log("stray", 0, 64'h0, 0);

        // reset during WAIT_DONE with three entries queued
        busy = 1'b1;
        for (int i = 0; i < 4; i++) push(7'(8'h60 + i), 1'b0, 1'b0);
        busy = 1'b0;
        repeat (5) @(negedge clk);
        chk("pre_rst_level", 1, 32'(lvl1), 32'd3);
        chk_log("pre_rst", 1, 64'h60, 1);
        chk_log("pre_rst", 0, 64'h60, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst_level", 1, 32'(lvl1), 32'd0);
        chk("rst_data", 1, 32'(txd1), 32'd0);
        chk("rst_ovf", 1, 32'(ovf1), 32'd0);
        chk("rst_empty", 0, 32'(emp0), 32'd1);
        repeat (100) @(negedge clk);
        chk_log("post_rst", 1, 64'h0, 0);
        chk_log("post_rst", 0, 64'h0, 0);

        // overflow counter saturation
        busy = 1'b1;
        for (int i = 0; i < 262; i++) push(7'(i), 1'b0, 1'b0);
        chk("ovf_sat", 1, 32'(ovf1), 32'd255);
        chk("ovf_count", 0, 32'(ovf0), 32'd246);
        chk("deep_full", 0, 32'(ful0), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
